iir_deemph: RTL and testbench
=============================

Name: iir_deemph

Overview:
- First-order IIR de-emphasis stage. Sits directly downstream of fir_top in the radio datapath.
- Pops signed samples from the FIR output FIFO, which is first-word-fall-through (FWFT).
- Computes a fixed-point recursive filter and pushes results into the next stage's input FIFO.
- Unity DC gain with the default coefficients; fully stalls on upstream empty or downstream full.

Parameters:
- DATA_WIDTH, 16, sample width. Signed two's complement in and out.
- COEFF_WIDTH, 16, signed coefficient width.
- FRAC_BITS, 10, coefficient quantization shift (dequantize = arithmetic right shift).
- X0, 178, signed feed-forward coefficient applied to x[n].
- X1, 178, signed feed-forward coefficient applied to x[n-1].
- Y1, 668, signed feedback coefficient applied to y[n-1].

Ports:
- clk  in  1  clock.
- rst  in  1  reset (synchronous, active-high).
- in_dout  in  DATA_WIDTH  head word of upstream FWFT FIFO; valid while in_empty=0.
- in_empty  in  1  upstream FIFO empty.
- in_rd_en  out  1  pop upstream FIFO; one-cycle pulse.
- out_din  out  DATA_WIDTH  result word to downstream FIFO.
- out_full  in  1  downstream FIFO full.
- out_wr_en  out  1  push downstream FIFO; one-cycle pulse.

Behaviour:
- Clocking and reset
  - One clock domain, clk.
  - rst is synchronous and active-high. On reset: state=S_READ; in_rd_en=0, out_wr_en=0, out_din=0; x_prev=0, y_prev=0, acc=0.
  - Reset mid-operation discards any in-flight sample (no write issued) and clears history.
- FSM, three states, one sample per 3 cycles minimum
  - S_READ: if in_empty=0, register x=in_dout, drive in_rd_en=1 this cycle, go S_MAC. Else stay; in_rd_en=0.
  - S_MAC: acc <= X0*x + X1*x_prev + Y1*y_prev. Go S_WRITE.
  - S_WRITE: if out_full=0, drive out_wr_en=1 and out_din=y, where y=result(acc); update x_prev<=x and y_prev<=y; go S_READ. Else hold all state, out_wr_en=0.
- in_rd_en and out_wr_en are combinational decodes of state and FIFO flags. They are never asserted together and never asserted when empty/full respectively.
- Latency: sample popped in cycle T; out_wr_en asserted in cycle T+2 when out_full=0. Each stall cycle on out_full adds one.
- Arithmetic
  - Products are full DATA_WIDTH+COEFF_WIDTH signed.
  - acc width is DATA_WIDTH+COEFF_WIDTH+2 (sum of three products, no internal overflow).
  - y = acc >>> FRAC_BITS (floor), then reduced to DATA_WIDTH per the optional feature.
  - y_prev stores the reduced y, i.e. exactly what was written.
- out_din holds its last value between writes.

Optional Feature:
- Macro: IIR_SATURATE_EN.
- Defined: shifted result is clamped to [-(2^(DATA_WIDTH-1)), 2^(DATA_WIDTH-1)-1]. The clamped value is both output and fed back.
- Undefined: shifted result is truncated to its low DATA_WIDTH bits (two's-complement wrap).

Test Plan:
- Impulse, defaults: input 1024, 0, 0 -> outputs 178, 294, 191 in order; in_rd_en pulses exactly 3 times.
- DC step, defaults: 40 samples of 1024 -> output non-decreasing, reaches 1022 and holds 1022 (floor fixed point) through sample 40.
- Backpressure: hold out_full=1 for 10 cycles while in S_WRITE -> out_wr_en=0 and in_rd_en=0 throughout; the held value is written once on release, no sample lost or duplicated.
- Upstream starvation: in_empty=1 for 20 cycles between two samples -> FSM idles in S_READ; next output matches the same values as an unstarved run.
- Overflow, X0=X1=2048, Y1=0, input 20000 -> with IIR_SATURATE_EN output 32767; without it, output -25536.
- Reset mid-sample: assert rst in S_MAC after popping 500 -> no write occurs. Post-reset impulse 1024 yields 178 (history cleared).

Source files
------------

// File: rtl/iir_deemph.sv
//------------------------------------------------------------------------------
// iir_deemph : first-order IIR de-emphasis between two FWFT/standard FIFOs.
// Optional macro IIR_SATURATE_EN clamps results instead of wrapping them.
// Revision   : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module iir_deemph #(
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int FRAC_BITS   = 10,
  parameter int X0          = 178,
  parameter int X1          = 178,
  parameter int Y1          = 668
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_dout,
  input  logic                  in_empty,
  output logic                  in_rd_en,
  output logic [DATA_WIDTH-1:0] out_din,
  input  logic                  out_full,
  output logic                  out_wr_en
);

  localparam int PW = DATA_WIDTH + COEFF_WIDTH;
  localparam int AW = PW + 2;

  localparam logic signed [COEFF_WIDTH-1:0] C_X0 = COEFF_WIDTH'(X0);
  localparam logic signed [COEFF_WIDTH-1:0] C_X1 = COEFF_WIDTH'(X1);
  localparam logic signed [COEFF_WIDTH-1:0] C_Y1 = COEFF_WIDTH'(Y1);

  typedef enum logic [1:0] {
    S_READ  = 2'd0,
    S_MAC   = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic signed [DATA_WIDTH-1:0] x_q, x_d;
  logic signed [DATA_WIDTH-1:0] x_prev_q, x_prev_d;
  logic signed [DATA_WIDTH-1:0] y_prev_q, y_prev_d;
  logic signed [AW-1:0]         acc_q, acc_d;

  logic signed [PW-1:0]         prod_x0, prod_x1, prod_y1;
  logic signed [DATA_WIDTH-1:0] y;

  // Operands widened first so each product is computed at full precision.
  assign prod_x0 = PW'(x_q)      * PW'(C_X0);
  assign prod_x1 = PW'(x_prev_q) * PW'(C_X1);
  assign prod_y1 = PW'(y_prev_q) * PW'(C_Y1);

`ifdef IIR_SATURATE_EN
  localparam logic signed [AW-1:0] MAX_V = {{(AW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] MIN_V = ~MAX_V;

  logic signed [AW-1:0] shifted;
  assign shifted = acc_q >>> FRAC_BITS;

  always_comb begin
    y = shifted[DATA_WIDTH-1:0];
    if (shifted > MAX_V) begin
      y = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (shifted < MIN_V) begin
      y = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end
  end
`else
  assign y = DATA_WIDTH'(acc_q >>> FRAC_BITS);
`endif

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    x_prev_d  = x_prev_q;
    y_prev_d  = y_prev_q;
    acc_d     = acc_q;
    in_rd_en  = 1'b0;
    out_wr_en = 1'b0;
    case (state_q)
      S_READ: begin
        if (!in_empty) begin
          x_d      = $signed(in_dout);
          in_rd_en = 1'b1;
          state_d  = S_MAC;
        end
      end
      S_MAC: begin
        acc_d   = AW'(prod_x0) + AW'(prod_x1) + AW'(prod_y1);
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (!out_full) begin
          out_wr_en = 1'b1;
          x_prev_d  = x_q;
          y_prev_d  = y;
          state_d   = S_READ;
        end
      end
      default: state_d = S_READ;
    endcase
  end

  // y_prev_q is exactly the last word written, so it doubles as the held output.
  assign out_din = (state_q == S_WRITE) ? y : y_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_READ;
      x_q      <= '0;
      x_prev_q <= '0;
      y_prev_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      x_prev_q <= x_prev_d;
      y_prev_q <= y_prev_d;
      acc_q    <= acc_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_iir_deemph.sv
//------------------------------------------------------------------------------
// tb_iir_deemph : directed + random checks of iir_deemph against a reference.
// Revision      : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_iir_deemph;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [15:0]        in_dout  = '0;
  logic               in_empty = 1'b1;
  logic               in_rd_en;
  logic signed [15:0] out_din;
  logic               out_full = 1'b0;
  logic               out_wr_en;

  logic [15:0]        o_in_dout  = '0;
  logic               o_in_empty = 1'b1;
  logic               o_in_rd_en;
  logic signed [15:0] o_out_din;
  logic               o_out_full = 1'b0;
  logic               o_out_wr_en;

  always #5 clk = ~clk;

  iir_deemph dut (
    .clk(clk), .rst(rst),
    .in_dout(in_dout), .in_empty(in_empty), .in_rd_en(in_rd_en),
    .out_din(out_din), .out_full(out_full), .out_wr_en(out_wr_en)
  );

  iir_deemph #(.X0(2048), .X1(2048), .Y1(0)) dut_ovf (
    .clk(clk), .rst(rst),
    .in_dout(o_in_dout), .in_empty(o_in_empty), .in_rd_en(o_in_rd_en),
    .out_din(o_out_din), .out_full(o_out_full), .out_wr_en(o_out_wr_en)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int rd_cnt   = 0;
  int wr_cnt   = 0;
  int viol_cnt = 0;

  always @(posedge clk) begin
    if (in_rd_en)  rd_cnt <= rd_cnt + 1;
    if (out_wr_en) wr_cnt <= wr_cnt + 1;
    if ((in_rd_en && out_wr_en) || (in_rd_en && in_empty) || (out_wr_en && out_full))
      viol_cnt <= viol_cnt + 1;
  end

  // Reference: y[n] = floor((178 x[n] + 178 x[n-1] + 668 y[n-1]) / 1024), then reduced.
  longint xp_m = 0;
  longint yp_m = 0;

  function automatic longint reduce16(longint v);
`ifdef IIR_SATURATE_EN
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
`else
    longint w;
    w = v & 64'hFFFF;
    return (w >= 32768) ? w - 65536 : w;
`endif
  endfunction

  task automatic model(input longint x, output longint y);
    longint s;
    s = 178 * x + 178 * xp_m + 668 * yp_m;
    y = reduce16(s >>> 10);
    xp_m = x;
    yp_m = y;
  endtask

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One sample through the pipe: pop, MAC, optional stall cycles, write.
  task automatic send(input longint x, input int stall, input string tag, output longint y_obs);
    longint y_exp;
    bit     got;
    model(x, y_exp);
    @(negedge clk);
    in_dout  = 16'(x);
    in_empty = 1'b0;
    #1;
    got = in_rd_en;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk); #1;
      got = in_rd_en;
    end
    check({tag, "_pop"}, longint'(got), 1);
    @(negedge clk);
    in_dout  = ~16'(x);
    out_full = (stall > 0);
    #1;
    check({tag, "_mac"}, longint'({in_rd_en, out_wr_en}), 0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk); #1;
      check({tag, "_stall"}, longint'({in_rd_en, out_wr_en}), 0);
    end
    @(negedge clk);
    in_empty = 1'b1;
    out_full = 1'b0;
    #1;
    check({tag, "_wr"}, longint'({in_rd_en, out_wr_en}), 1);
    y_obs = longint'(out_din);
    check({tag, "_val"}, y_obs, y_exp);
    @(negedge clk); #1;
    check({tag, "_once"}, longint'(out_wr_en), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    xp_m = 0;
    yp_m = 0;
  endtask

  initial begin
    longint y, y_prev;
    int     rd0, wr0;
    logic signed [15:0] r;

    repeat (3) @(negedge clk);
    #1;
    check("rst_rd", longint'(in_rd_en), 0);
    check("rst_wr", longint'(out_wr_en), 0);
    check("rst_dout", longint'(out_din), 0);
    rst = 1'b0;

    // Impulse response.
    rd0 = rd_cnt;
    send(1024, 0, "imp0", y); check("imp0_const", y, 178);
    send(0,    0, "imp1", y); check("imp1_const", y, 294);
    send(0,    0, "imp2", y); check("imp2_const", y, 191);
    check("imp_rd_pulses", longint'(rd_cnt - rd0), 3);

    // DC step from cleared history.
    do_reset();
    y_prev = -100000;
    for (int i = 0; i < 40; i++) begin
      send(1024, 0, "dc", y);
      check("dc_mono", longint'(y >= y_prev), 1);
      y_prev = y;
    end
    check("dc_final", y, 1022);

    // Backpressure: ten held cycles, exactly one write.
    wr0 = wr_cnt;
    send(1024, 10, "bp", y);
    check("bp_val", y, 1022);
    check("bp_one_write", longint'(wr_cnt - wr0), 1);

    // Upstream starvation.
    send(-3000, 0, "starve_a", y);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      check("starve_idle", longint'({in_rd_en, out_wr_en}), 0);
    end
    send(2500, 0, "starve_b", y);

    // Random samples with random stalls and gaps.
    for (int i = 0; i < 40; i++) begin
      r = 16'($urandom);
      send(longint'(r), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, "rnd", y);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Overflow on the wide-coefficient instance.
    @(negedge clk);
    o_in_dout  = 16'd20000;
    o_in_empty = 1'b0;
    #1;
    check("ovf_pop", longint'(o_in_rd_en), 1);
    @(negedge clk);
    o_in_empty = 1'b1;
    @(negedge clk); #1;
    check("ovf_wr", longint'(o_out_wr_en), 1);
`ifdef IIR_SATURATE_EN
    check("ovf_val", longint'(o_out_din), 32767);
`else
    check("ovf_val", longint'(o_out_din), -25536);
`endif

    // Reset while a popped sample sits in S_MAC.
    @(negedge clk);
    in_dout  = 16'd500;
    in_empty = 1'b0;
    #1;
    check("mid_pop", longint'(in_rd_en), 1);
    @(negedge clk);
    in_empty = 1'b1;
    rst      = 1'b1;
    #1;
    check("mid_mac_wr", longint'(out_wr_en), 0);
    wr0 = wr_cnt;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("mid_no_wr", longint'(out_wr_en), 0);
    end
    check("mid_wr_count", longint'(wr_cnt - wr0), 0);
    check("mid_dout_clr", longint'(out_din), 0);
    xp_m = 0;
    yp_m = 0;
    send(1024, 0, "post_rst", y);
    check("post_rst_const", y, 178);

    @(negedge clk);
    check("handshake_viol", longint'(viol_cnt), 0);
    check("pop_vs_push", longint'(rd_cnt - wr_cnt), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: observed no completion expected finish before 500000ns");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
